// File: rtl/state_recorder.sv
// Shadow recorder for write-only NES hardware state (PPU/APU/IO registers plus a write log),
// snooped from the CPU bus and read back by the launcher through a registered 9-bit port.
module state_recorder #(
    parameter int          LOG_DEPTH = 64,
    parameter logic [15:0] LOG_BASE  = 16'h4020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_rw,
    input  logic        freeze,
    input  logic        clear,
    input  logic [8:0]  rd_addr,
    output logic [7:0]  rd_data
);

    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    // M2 synchroniser and falling-edge detector
    logic m2_s1, m2_s2, m2_d;

    // Bus cycle latched while synced M2 is high
    logic [15:0] lat_addr;
    logic [7:0]  lat_data;
    logic        lat_rw;

    // Shadow state
    logic [7:0]  ppu_reg [0:7];
    logic [7:0]  scroll_x, scroll_y;
    logic [13:0] vaddr;
    logic        w_tog;
    logic [7:0]  apu_reg [0:23];
    logic [7:0]  log_count;
    logic [PW-1:0] wr_ptr;
    logic        ovf;

    // Write-log storage; no reset so it can map onto block RAM
    logic [15:0] log_addr_mem [0:LOG_DEPTH-1];
    logic [7:0]  log_data_mem [0:LOG_DEPTH-1];

    logic wipe, commit;
    logic is_ppu, is_apu, is_log, log_wr;
    logic [5:0] ptr6;
    logic [5:0] rd_n;
    logic [7:0] rd_next;

    assign wipe   = reset | clear;
    assign commit = m2_d & ~m2_s2 & ~freeze;

    assign is_ppu = (lat_addr[15:13] == 3'b001);
    assign is_apu = (lat_addr >= 16'h4000) && (lat_addr <= 16'h4017);
    assign is_log = !lat_rw && (lat_addr >= LOG_BASE) && (lat_addr >= 16'h2000)
                    && !((lat_addr >= 16'h4018) && (lat_addr <= 16'h401F));
    assign log_wr = commit & is_log;

    assign ptr6 = 6'(wr_ptr);
    assign rd_n = rd_addr[7:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            m2_s1    <= 1'b0;
            m2_s2    <= 1'b0;
            m2_d     <= 1'b0;
            lat_addr <= 16'h0000;
            lat_data <= 8'h00;
            lat_rw   <= 1'b1;
        end else begin
            m2_s1 <= m2;
            m2_s2 <= m2_s1;
            m2_d  <= m2_s2;
            if (m2_s2) begin
                lat_addr <= cpu_addr;
                lat_data <= cpu_data;
                lat_rw   <= cpu_rw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < 8; i++) ppu_reg[i] <= 8'h00;
            for (int i = 0; i < 24; i++) apu_reg[i] <= 8'h00;
            scroll_x  <= 8'h00;
            scroll_y  <= 8'h00;
            vaddr     <= 14'h0000;
            w_tog     <= 1'b0;
            log_count <= 8'h00;
            wr_ptr    <= '0;
            ovf       <= 1'b0;
        end else if (commit) begin
            if (!lat_rw && is_ppu) begin
                ppu_reg[lat_addr[2:0]] <= lat_data;
                case (lat_addr[2:0])
                    3'd5: begin
                        if (!w_tog) scroll_x <= lat_data;
                        else        scroll_y <= lat_data;
                        w_tog <= ~w_tog;
                    end
                    3'd6: begin
                        if (!w_tog) vaddr[13:8] <= lat_data[5:0];
                        else        vaddr[7:0]  <= lat_data;
                        w_tog <= ~w_tog;
                    end
                    // Increment step comes from the $2000 shadow as it was before this cycle
                    3'd7: vaddr <= vaddr + (ppu_reg[0][2] ? 14'd32 : 14'd1);
                    default: ;
                endcase
            end
            if (lat_rw && is_ppu && (lat_addr[2:0] == 3'd2))
                w_tog <= 1'b0;
            if (!lat_rw && is_apu)
                apu_reg[lat_addr[4:0]] <= lat_data;
            if (log_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (log_count == 8'(LOG_DEPTH)) ovf       <= 1'b1;
                else                            log_count <= log_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (log_wr && !wipe) begin
            log_addr_mem[wr_ptr] <= lat_addr;
            log_data_mem[wr_ptr] <= lat_data;
        end
    end

    // Read port: rd_data reflects rd_addr one clk later; a commit landing in the same clk
    // is seen on the following read. No handshake, every clk is a read.
    always_comb begin
        rd_next = 8'h00;
        if (rd_addr[8]) begin
            // Entries never written since reset/clear read as zero
            if ((int'(rd_n) < LOG_DEPTH) && ({2'b00, rd_n} < log_count)) begin
                case (rd_addr[1:0])
                    2'd0: rd_next = log_addr_mem[rd_n[PW-1:0]][7:0];
                    2'd1: rd_next = log_addr_mem[rd_n[PW-1:0]][15:8];
                    2'd2: rd_next = log_data_mem[rd_n[PW-1:0]];
                    default: rd_next = 8'h00;
                endcase
            end
        end else if (rd_addr[7:3] == 5'd0) begin
            rd_next = ppu_reg[rd_addr[2:0]];
        end else if ((rd_addr[7:5] == 3'b001) && (rd_addr[4:0] < 5'd24)) begin
            rd_next = apu_reg[rd_addr[4:0]];
        end else begin
            case (rd_addr[7:0])
                8'h08: rd_next = scroll_x;
                8'h09: rd_next = scroll_y;
                8'h0A: rd_next = {2'b00, vaddr[13:8]};
                8'h0B: rd_next = vaddr[7:0];
                8'h0C: rd_next = {7'b0, w_tog};
                8'h0D: rd_next = log_count;
                8'h0E: rd_next = {ovf, 1'b0, ptr6};
                default: rd_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wipe) rd_data <= 8'h00;
        else      rd_data <= rd_next;
    end

endmodule
